// File: rtl/hv_timing_pkg.sv
// hv_timing_pkg: shared timing constants and count type; HV_TIMING_PAL_EN selects PAL frame defaults.
package hv_timing_pkg;
  typedef logic [8:0] cnt_t;
  localparam int NTSC_H_LAST = 340;
  localparam int NTSC_V_VBL  = 241;
  localparam int NTSC_V_LAST = 261;
  localparam int PAL_H_LAST  = 340;
  localparam int PAL_V_VBL   = 241;
  localparam int PAL_V_LAST  = 311;
`ifdef HV_TIMING_PAL_EN
  localparam int DEF_H_LAST = PAL_H_LAST;
  localparam int DEF_V_VBL  = PAL_V_VBL;
  localparam int DEF_V_LAST = PAL_V_LAST;
`else
  localparam int DEF_H_LAST = NTSC_H_LAST;
  localparam int DEF_V_VBL  = NTSC_V_VBL;
  localparam int DEF_V_LAST = NTSC_V_LAST;
`endif
endpackage

// File: rtl/hv_vbl_flag.sv
// hv_vbl_flag: vblank status flag with read-race suppression and active-low interrupt.
module hv_vbl_flag
  import hv_timing_pkg::*;
#(
  parameter int V_VBL  = DEF_V_VBL,
  parameter int V_LAST = DEF_V_LAST
) (
  input  logic       PCLK,
  input  logic       n_RES,
  input  logic [8:0] H_in,
  input  logic [8:0] V_in,
  input  logic       nmi_en,
  input  logic       rd_status,
  output logic       vbl_flag,
  output logic       n_INT
);
  logic set_cyc, clr_cyc;
  assign set_cyc = (V_in == cnt_t'(V_VBL)) & (H_in == 9'd1);
  // A status read in the set cycle wins, so the CPU never misses and re-sees the flag.
  assign clr_cyc = rd_status | ((V_in == cnt_t'(V_LAST)) & (H_in == 9'd1));
  always_ff @(posedge PCLK or negedge n_RES)
    if (!n_RES) vbl_flag <= 1'b0;
    else vbl_flag <= clr_cyc ? 1'b0 : (set_cyc ? 1'b1 : vbl_flag);
  assign n_INT = ~(vbl_flag & nmi_en);
endmodule

// File: rtl/hv_timing_ctrl.sv
// hv_timing_ctrl: registered line/frame end decode, odd-frame skip and frame parity.
// HV_TIMING_PAL_EN selects PAL frame length and removes the odd-frame skip.
module hv_timing_ctrl
  import hv_timing_pkg::*;
#(
  parameter int H_LAST = DEF_H_LAST,
  parameter int V_VBL  = DEF_V_VBL,
  parameter int V_LAST = DEF_V_LAST
) (
  input  logic       PCLK,
  input  logic       n_RES,
  input  logic [8:0] H_in,
  input  logic [8:0] V_in,
  input  logic       render_en,
  input  logic       nmi_en,
  input  logic       rd_status,
  output logic       HC,
  output logic       VC,
  output logic       V_IN,
  output logic       vbl_flag,
  output logic       n_INT,
  output logic       odd_frame,
  output logic       visible
);
  logic last_line, skip, line_end;
  cnt_t end_h;
  assign last_line = V_in == cnt_t'(V_LAST);
`ifdef HV_TIMING_PAL_EN
  assign skip = 1'b0;
`else
  assign skip = odd_frame & render_en & last_line;
`endif
  // Decode one count early so the clears land in the line's final cycle.
  assign end_h    = skip ? cnt_t'(H_LAST - 2) : cnt_t'(H_LAST - 1);
  assign line_end = (V_in <= cnt_t'(V_LAST)) & (H_in == end_h);
  always_ff @(posedge PCLK or negedge n_RES)
    if (!n_RES) begin
      HC        <= 1'b0;
      VC        <= 1'b0;
      V_IN      <= 1'b0;
      odd_frame <= 1'b0;
    end else begin
      HC   <= line_end;
      V_IN <= line_end;
      VC   <= line_end & last_line;
      if (VC) odd_frame <= ~odd_frame;
    end
  assign visible = (V_in < 9'd240) & (H_in != 9'd0) & (H_in <= 9'd256);
  hv_vbl_flag #(.V_VBL(V_VBL), .V_LAST(V_LAST)) u_vbl (
    .PCLK(PCLK), .n_RES(n_RES), .H_in(H_in), .V_in(V_in),
    .nmi_en(nmi_en), .rd_status(rd_status), .vbl_flag(vbl_flag), .n_INT(n_INT)
  );
endmodule

// File: tb/tb_hv_timing_ctrl.sv
// tb_hv_timing_ctrl: randomized line/frame traffic against a frame-level reference model with a scoreboard.
module tb_hv_timing_ctrl;
`ifdef HV_TIMING_PAL_EN
  localparam int VL = 311;
  localparam bit PAL = 1'b1;
`else
  localparam int VL = 261;
  localparam bit PAL = 1'b0;
`endif
  localparam int HL = 340;
  localparam int VB = 241;
  localparam int NCYC = 40000;

  logic PCLK = 1'b0, n_RES = 1'b0;
  logic [8:0] H_in = '0, V_in = '0;
  logic render_en = 1'b0, nmi_en = 1'b0, rd_status = 1'b0;
  logic HC, VC, V_IN, vbl_flag, n_INT, odd_frame, visible;

  hv_timing_ctrl dut (
    .PCLK(PCLK), .n_RES(n_RES), .H_in(H_in), .V_in(V_in), .render_en(render_en),
    .nmi_en(nmi_en), .rd_status(rd_status), .HC(HC), .VC(VC), .V_IN(V_IN),
    .vbl_flag(vbl_flag), .n_INT(n_INT), .odd_frame(odd_frame), .visible(visible)
  );

  always #5 PCLK = ~PCLK;

  typedef struct packed {
    logic hc, vc, vin, vbl, odd, nint, vis;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;

  bit m_hc, m_vc, m_vin, m_vbl;
  int m_frames;

  task automatic check(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t H=%0d V=%0d got %b expected %b", name, $time, H_in, V_in, act, req);
    end
  endtask

  task automatic model_reset();
    m_hc = 0; m_vc = 0; m_vin = 0; m_vbl = 0; m_frames = 0;
  endtask

  // Edge update: the line's final count is H_LAST, or one less on the odd-frame short line.
  task automatic model_edge();
    int last_h;
    bit le;
    if (!n_RES) return;
    last_h = (!PAL && int'(V_in) == VL && (m_frames % 2 == 1) && render_en) ? HL - 1 : HL;
    le = int'(V_in) <= VL && int'(H_in) == last_h - 1;
    if (m_vc) m_frames++;
    m_hc = le;
    m_vin = le;
    m_vc = le && int'(V_in) == VL;
    if (rd_status || (int'(V_in) == VL && H_in == 9'd1)) m_vbl = 0;
    else if (int'(V_in) == VB && H_in == 9'd1) m_vbl = 1;
  endtask

  always @(negedge PCLK) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      check("HC", HC, e.hc);
      check("VC", VC, e.vc);
      check("V_IN", V_IN, e.vin);
      check("vbl_flag", vbl_flag, e.vbl);
      check("odd_frame", odd_frame, e.odd);
      check("n_INT", n_INT, e.nint);
      check("visible", visible, e.vis);
    end
  end

  initial begin
    int ch, cv, rst_left, lines[7];
    bit old_hc, old_vc, garbage, done_rst;
    exp_t e;
    lines = '{VB - 1, VB, VL - 1, VL, VL, 10, 239};
    ch = 190; cv = 100; rst_left = 3; done_rst = 0; garbage = 0;
    model_reset();
    for (int c = 0; c < NCYC; c++) begin
      @(posedge PCLK);
      old_hc = m_hc;
      old_vc = m_vc;
      model_edge();
      #1;
      if (old_hc) begin
        ch = 0;
        cv = old_vc ? 0 : cv + 1;
      end else if (!garbage) ch++;
      if (ch > HL) begin
        ch = 0;
        cv = cv + 1;
      end
      if (cv > VL) cv = 0;
      if (ch == 0) begin
        if ($urandom_range(0, 1) == 1) cv = lines[$urandom_range(0, 6)];
        if ($urandom_range(0, 1) == 1) render_en = $urandom_range(0, 3) != 0;
      end
      if ($urandom_range(0, 49) == 0) nmi_en = ~nmi_en;
      if (cv == VB && ch == 1 && $urandom_range(0, 2) == 0) rd_status = 1;
      else rd_status = $urandom_range(0, 99) == 0;
      garbage = $urandom_range(0, 299) == 0;
      if (garbage && $urandom_range(0, 1) == 1) begin
        H_in = 9'($urandom_range(HL + 1, 511));
        V_in = 9'(cv);
      end else if (garbage) begin
        H_in = 9'(ch);
        V_in = 9'($urandom_range(VL + 1, 511));
      end else begin
        H_in = 9'(ch);
        V_in = 9'(cv);
      end
      if (!done_rst && cv == 100 && ch == 200) begin
        rst_left = 2;
        done_rst = 1;
      end else if (rst_left == 0 && $urandom_range(0, 3999) == 0) rst_left = $urandom_range(1, 3);
      if (rst_left > 0) begin
        n_RES = 1'b0;
        rst_left--;
        model_reset();
      end else n_RES = 1'b1;
      e.hc = m_hc;
      e.vc = m_vc;
      e.vin = m_vin;
      e.vbl = m_vbl;
      e.odd = m_frames % 2 == 1;
      e.nint = !(m_vbl && nmi_en);
      e.vis = int'(V_in) < 240 && H_in >= 9'd1 && H_in <= 9'd256;
      q.push_back(e);
    end
    @(negedge PCLK);
    @(negedge PCLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
